// File: rtl/dual_port_reg_file_if.sv
// Bus bundle for the register file: write source operands, mux select,
// read/write addresses and the two combinational read results.
interface dual_port_reg_file_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
);
  localparam int AW = $clog2(NREGS);

  logic              we;
  logic [DATA_W-1:0] OR2;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [DATA_W-1:0] ALU_IN;
  logic [1:0]        mux_sel;
  logic [AW-1:0]     read_seg;
  logic [AW-1:0]     write_seg;
  logic [DATA_W-1:0] dataout_A;
  logic [DATA_W-1:0] dataout_B;

  // Datapath controller side: drives operands and addresses, sees read data
  modport master (
    output we, OR2, A_in, B_in, ALU_IN, mux_sel, read_seg, write_seg,
    input  dataout_A, dataout_B
  );

  // Register file side
  modport slave (
    input  we, OR2, A_in, B_in, ALU_IN, mux_sel, read_seg, write_seg,
    output dataout_A, dataout_B
  );
endinterface

// File: rtl/dual_port_reg_file.sv
// 8x8 general-purpose register file: one muxed write port, two
// asynchronous read ports (A at read_seg, B at the write address so the
// destination's current value is always visible). No write-through bypass.
module dual_port_reg_file #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  dual_port_reg_file_if.slave  bus
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]            wdata;

  // Write-data source select
  always_comb begin
    wdata = bus.ALU_IN;
    case (bus.mux_sel)
      2'b00:   wdata = bus.ALU_IN;
      2'b01:   wdata = bus.B_in;
      2'b10:   wdata = bus.A_in;
      default: wdata = bus.OR2;
    endcase
  end

  // Next-state: only the addressed register takes the write data
  always_comb begin
    regs_d = regs_q;
    if (bus.we) regs_d[bus.write_seg] = wdata;
  end

  // Storage; clear wins over any write in the same cycle
  always_ff @(posedge clk) begin
    if (clr) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign bus.dataout_A = regs_q[bus.read_seg];
  assign bus.dataout_B = regs_q[bus.write_seg];

endmodule

// File: tb/tb_dual_port_reg_file.sv
// Directed test-plan walk followed by randomized traffic, checked against
// an array model of the eight registers.
module tb_dual_port_reg_file;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  dual_port_reg_file_if #(.DATA_W(8), .NREGS(8)) bus ();

  dual_port_reg_file #(.DATA_W(8), .NREGS(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  logic [7:0] model [8];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Both ports against the model at the current addresses
  task automatic chk_ports(input string tag);
    #1;
    chk({tag, "_A"}, bus.dataout_A, model[bus.read_seg]);
    chk({tag, "_B"}, bus.dataout_B, model[bus.write_seg]);
  endtask

  // One rising edge; model follows the clear/write rules on the sampled inputs
  task automatic tick();
    logic [7:0] src [4];
    src[0] = bus.ALU_IN; src[1] = bus.B_in; src[2] = bus.A_in; src[3] = bus.OR2;
    @(posedge clk);
    if (clr)         foreach (model[i]) model[i] = 8'h00;
    else if (bus.we) model[bus.write_seg] = src[bus.mux_sel];
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.read_seg = 3'(i); bus.write_seg = 3'(7 - i);
      #1;
      chk({tag, "_A"}, bus.dataout_A, 8'h00);
      chk({tag, "_B"}, bus.dataout_B, 8'h00);
    end
  endtask

  initial begin
    bus.we = 1'b0; bus.OR2 = '0; bus.A_in = '0; bus.B_in = '0; bus.ALU_IN = '0;
    bus.mux_sel = 2'b00; bus.read_seg = '0; bus.write_seg = '0;

    // Clear with a write also requested
    @(negedge clk);
    clr = 1'b1; bus.we = 1'b1; bus.ALU_IN = 8'hAF; bus.write_seg = 3'd5;
    tick();
    clr = 1'b0;
    chk_all_zero("clear");

    // OR2 write to reg1
    bus.we = 1'b1; bus.mux_sel = 2'b11; bus.write_seg = 3'd1; bus.OR2 = 8'hFE;
    bus.read_seg = 3'd0;
    #1 chk("or2_pre_B", bus.dataout_B, 8'h00);
    tick();
    chk("or2_B", bus.dataout_B, 8'hFE);
    bus.read_seg = 3'd1;
    #1 chk("or2_A", bus.dataout_A, 8'hFE);

    // A_in write to reg0; reg1 untouched
    bus.mux_sel = 2'b10; bus.write_seg = 3'd0; bus.A_in = 8'hCF;
    tick();
    chk("ain_B", bus.dataout_B, 8'hCF);
    chk("ain_keep_A", bus.dataout_A, 8'hFE);

    // ALU overwrite of reg1, read and write same address
    bus.mux_sel = 2'b00; bus.write_seg = 3'd1; bus.ALU_IN = 8'hAF;
    #1 chk("alu_old_A", bus.dataout_A, 8'hFE);
    tick();
    chk("alu_A", bus.dataout_A, 8'hAF);
    chk("alu_B", bus.dataout_B, 8'hAF);

    // B_in write to reg2, then we=0 holds it
    bus.mux_sel = 2'b01; bus.write_seg = 3'd2; bus.B_in = 8'hCC;
    tick();
    bus.read_seg = 3'd2;
    #1 chk("bin_A", bus.dataout_A, 8'hCC);
    bus.we = 1'b0; bus.mux_sel = 2'b11; bus.OR2 = 8'h55;
    tick(); tick();
    chk("hold_A", bus.dataout_A, 8'hCC);
    chk("hold_B", bus.dataout_B, 8'hCC);
    bus.read_seg = 3'd0;
    #1 chk("hold_r0", bus.dataout_A, 8'hCF);

    // Clear vs write collision
    clr = 1'b1; bus.we = 1'b1; bus.mux_sel = 2'b11; bus.OR2 = 8'h77; bus.write_seg = 3'd3;
    tick();
    clr = 1'b0;
    chk_all_zero("collide");

    // Randomized traffic; old value visible before the edge, new after
    for (int n = 0; n < 300; n++) begin
      clr          = ($urandom_range(0, 19) == 0);
      bus.we       = 1'($urandom);
      bus.mux_sel  = 2'($urandom);
      bus.OR2      = 8'($urandom);
      bus.A_in     = 8'($urandom);
      bus.B_in     = 8'($urandom);
      bus.ALU_IN   = 8'($urandom);
      bus.write_seg = 3'($urandom);
      bus.read_seg  = 3'($urandom);
      chk_ports("rnd_pre");
      tick();
      clr = 1'b0;
      chk_ports("rnd_post");
      bus.read_seg = 3'($urandom);
      chk_ports("rnd_raddr");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, observed %0d checks", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_port_reg_file.md
Name: dual_port_reg_file

Overview:
- 8-entry x 8-bit general-purpose register file for the RNBIP-2 datapath.
- One write port: data is chosen by a 4:1 source mux (ALU result, A bus, B bus, operand register OR2).
- Two asynchronous read ports: port A is addressed by read_seg; port B is addressed by write_seg, so the destination register's current value is always visible.
- Sits between the operand/ALU buses and the ALU input latches.

Parameters:
- DATA_W, 8, register and bus width.
- NREGS, 8, number of registers; address width is log2(NREGS) = 3.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous active-high clear of all registers.
- we  input  1  write enable, active high.
- OR2  input  8  write source when mux_sel = 2'b11.
- A_in  input  8  write source when mux_sel = 2'b10.
- B_in  input  8  write source when mux_sel = 2'b01.
- ALU_IN  input  8  write source when mux_sel = 2'b00.
- mux_sel  input  2  write-data source select.
- read_seg  input  3  port-A read address.
- write_seg  input  3  write address, also the port-B read address.
- dataout_A  output  8  reg[read_seg], combinational.
- dataout_B  output  8  reg[write_seg], combinational.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port clr.
- Storage: reg[0..7], each DATA_W bits. No register is hardwired; reg[0] is writable.
- Clear: at a rising clk edge with clr=1, all 8 registers become 8'h00.
  - clr has priority over we; a write requested in the same cycle is discarded.
  - Clear asserted mid-sequence takes effect at that edge; there is no partial state.
- Power-up contents are undefined until the first clr edge.
- Write data mux:
  - 00 -> ALU_IN
  - 01 -> B_in
  - 10 -> A_in
  - 11 -> OR2
- Write: at a rising clk edge with clr=0 and we=1, reg[write_seg] <= mux output.
  - If we=0, no register changes.
  - Only the addressed register changes.
- Reads are purely combinational from stored contents; there is no write-through bypass.
  - A value written at edge N appears on dataout_A/dataout_B immediately after edge N (zero-cycle latency after the edge).
  - During the cycle before edge N, the outputs show the old value.
  - After a clr edge, both outputs read 8'h00.
- Read/write same address (read_seg == write_seg): both outputs show the same register; both update together after the edge.
- Address changes on read_seg/write_seg change the outputs combinationally within the same cycle.
- All 3-bit addresses 0..7 are valid; there is no out-of-range case.

Test Plan:
- Clear: clr=1 for one edge, ALU_IN=8'hAF, we=X.
  - Response: every register = 00; both outputs read 00 for all addresses 0..7.
- OR2 write: clr=0, we=1, mux_sel=11, write_seg=1, OR2=FE, one edge.
  - Response: dataout_B=FE.
  - Then with read_seg=1: dataout_A=FE.
- A_in write: mux_sel=10, write_seg=0, A_in=CF, one edge.
  - Response: reg0=CF; reg1 still FE (read_seg=1 -> dataout_A=FE).
- ALU write then overwrite: mux_sel=00, write_seg=1, ALU_IN=AF, one edge.
  - Response: dataout_A=dataout_B=AF (read_seg=1).
- B_in write and read-address switch:
  - mux_sel=01, write_seg=2, B_in=CC, one edge, read_seg=2 -> dataout_A=CC.
  - Set we=0 with mux_sel=11, OR2=55: further edges leave reg2=CC.
- Clr vs write collision: clr=1, we=1, mux_sel=11, OR2=77, write_seg=3.
  - Response after edge: reg3=00 and all other registers 00.
